uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_fifo_mem.sv | 29 ++
 rtl/uart_rx_fifo.sv | 110 +++++++++++
 tb/tb_uart_rx_fifo.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: byte width, default FIFO
// depth and the width of a fill-level count for that depth.
package uart_pkg;

    localparam int BYTE_W     = 8;
    localparam int FIFO_DEPTH = 16;

    // A level counter must hold 0..depth inclusive, hence one extra bit.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int LEVEL_W = level_width(FIFO_DEPTH);

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte storage for the receive FIFO: one synchronous write port and one
// asynchronous read port so the head byte is visible without added latency.
// Contents are deliberately not reset.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = LEVEL_W - 1
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [BYTE_W-1:0] rd_data
);

    logic [BYTE_W-1:0] mem [DEPTH];

    // Store the incoming byte on an accepted push.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver. A rising edge on the receiver's
// byte-ready level pushes one byte; the consumer pops with a valid/ready
// handshake. Flags are decoded from the level register only, so they
// never glitch on pointer comparisons.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int AW     = LEVEL_W - 1,
    parameter int THRESH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rdy,
    input  logic [BYTE_W-1:0] din,
    input  logic              rd_ready,
    input  logic              clr_overrun,
    output logic              rd_valid,
    output logic [BYTE_W-1:0] rd_data,
    output logic [AW:0]       level,
    output logic              full,
    output logic              empty,
    output logic              overrun,
    output logic              thresh_irq
);

    logic          rdy_q;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   level_reg;
    logic          overrun_reg;

    logic push_stb;
    logic pop;
    logic wr_en;
    logic drop;

    // A full FIFO may still accept a byte if the head leaves on the same edge.
    assign push_stb = rdy & ~rdy_q;
    assign pop      = rd_valid & rd_ready;
    assign wr_en    = push_stb & (~full | pop);
    assign drop     = push_stb & full & ~pop;

    // Remember the previous rdy level; reset high so a level held through
    // reset is not mistaken for a new byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_q <= 1'b1;
        end else begin
            rdy_q <= rdy;
        end
    end

    // Advance the pointers on accepted pushes and pops; AW-bit wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
        end
    end

    // Track the fill level; a simultaneous push and pop cancel out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_reg <= '0;
        end else if (wr_en && !pop) begin
            level_reg <= level_reg + (AW+1)'(1);
        end else if (pop && !wr_en) begin
            level_reg <= level_reg - (AW+1)'(1);
        end
    end

    // Sticky overrun flag; a drop on the same edge as a clear keeps it set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_reg <= 1'b0;
        end else if (drop) begin
            overrun_reg <= 1'b1;
        end else if (clr_overrun) begin
            overrun_reg <= 1'b0;
        end
    end

    assign level      = level_reg;
    assign full       = (level_reg == (AW+1)'(DEPTH));
    assign empty      = (level_reg == '0);
    assign rd_valid   = ~empty;
    assign thresh_irq = (level_reg >= (AW+1)'(THRESH));
    assign overrun    = overrun_reg;

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_reg),
        .wr_data (din),
        .rd_addr (rd_ptr_reg),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a queue-based reference model is compared with
// the DUT on every falling clock edge, and directed scenarios add literal
// expectations at the points of interest.
module tb_uart_rx_fifo;

    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int THRESH = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       rdy;
    logic [7:0] din;
    logic       rd_ready;
    logic       clr_overrun;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic [AW:0] level;
    logic       full;
    logic       empty;
    logic       overrun;
    logic       thresh_irq;

    int n_cmp = 0;
    int n_err = 0;

    uart_rx_fifo #(
        .DEPTH  (DEPTH),
        .AW     (AW),
        .THRESH (THRESH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rdy         (rdy),
        .din         (din),
        .rd_ready    (rd_ready),
        .clr_overrun (clr_overrun),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .level       (level),
        .full        (full),
        .empty       (empty),
        .overrun     (overrun),
        .thresh_irq  (thresh_irq)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: contents as a queue, previous rdy level, sticky flag.
    logic [7:0] mq[$];
    logic       m_prev_rdy;
    logic       m_overrun;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_prev_rdy = 1'b1;
            m_overrun  = 1'b0;
        end else begin
            bit strobe;
            bit do_pop;
            strobe = rdy && !m_prev_rdy;
            do_pop = (mq.size() > 0) && rd_ready;
            if (do_pop) void'(mq.pop_front());
            if (strobe) begin
                if (mq.size() < DEPTH) mq.push_back(din);
                else m_overrun = 1'b1;
            end
            if (clr_overrun && !(strobe && mq.size() == DEPTH && !do_pop && !(mq.size() < DEPTH)))
                m_overrun = m_overrun && strobe && !do_pop && (mq.size() == DEPTH) && !clr_overrun;
            m_prev_rdy = rdy;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        int sz;
        sz = mq.size();
        chk("level",      int'(level),      sz);
        chk("empty",      int'(empty),      int'(sz == 0));
        chk("full",       int'(full),       int'(sz == DEPTH));
        chk("rd_valid",   int'(rd_valid),   int'(sz != 0));
        chk("thresh_irq", int'(thresh_irq), int'(sz >= THRESH));
        chk("overrun",    int'(overrun),    int'(m_overrun));
        if (sz != 0) chk("rd_data", int'(rd_data), int'(mq[0]));
    end

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_byte(input logic [7:0] b);
        din = b;
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b0; rdy = 1'b1; din = 8'h00; rd_ready = 1'b0; clr_overrun = 1'b0;
        #1;
        chk("rst_level",    int'(level),    0);
        chk("rst_empty",    int'(empty),    1);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_full",     int'(full),     0);
        chk("rst_thresh",   int'(thresh_irq), 0);
        chk("rst_overrun",  int'(overrun),  0);
        step(); step();
        reset = 1'b1;                       // rdy still high: must not push
        step(); step(); step();
        chk("rdy_thru_reset_level", int'(level), 0);

        // Long rdy pulse pushes a single byte.
        rdy = 1'b0; step();
        din = 8'hA5; rdy = 1'b1;
        for (int i = 0; i < 40; i++) step();
        chk("long_rdy_level", int'(level),   1);
        chk("long_rdy_data",  int'(rd_data), 8'hA5);
        rdy = 1'b0; rd_ready = 1'b1; step(); rd_ready = 1'b0;
        chk("long_rdy_drained", int'(empty), 1);

        // Fill to 16, watching the threshold.
        for (int i = 1; i <= 16; i++) begin
            push_byte(8'(i));
            chk($sformatf("thresh_after_%0d", i), int'(thresh_irq), int'(i >= 8));
        end
        chk("fill_full",  int'(full),  1);
        chk("fill_level", int'(level), 16);
        push_byte(8'hFF);
        chk("drop_overrun", int'(overrun), 1);
        chk("drop_level",   int'(level),   16);

        // Set and clear on the same edge: set wins; later clear alone.
        din = 8'hEE; rdy = 1'b1; clr_overrun = 1'b1; step();
        rdy = 1'b0; clr_overrun = 1'b0;
        chk("set_clr_same_edge", int'(overrun), 1);
        step();
        clr_overrun = 1'b1; step(); clr_overrun = 1'b0;
        chk("clr_alone", int'(overrun), 0);

        // Push while full with a pop on the same edge.
        chk("head_before_swap", int'(rd_data), 8'h01);
        din = 8'h77; rdy = 1'b1; rd_ready = 1'b1; step();
        rdy = 1'b0; rd_ready = 1'b0;
        chk("swap_level",   int'(level),   16);
        chk("swap_overrun", int'(overrun), 0);
        chk("swap_head",    int'(rd_data), 8'h02);
        step();

        // Drain: 0x02..0x10 then 0x77 last.
        rd_ready = 1'b1;
        for (int i = 2; i <= 16; i++) begin
            chk($sformatf("drain_%0d", i), int'(rd_data), i);
            step();
        end
        chk("drain_last", int'(rd_data), 8'h77);
        step();
        rd_ready = 1'b0;
        chk("drain_empty", int'(empty), 1);

        // Push into empty FIFO with rd_ready high: stored, popped next edge.
        din = 8'h3C; rdy = 1'b1; rd_ready = 1'b1; step();
        rdy = 1'b0;
        chk("empty_push_level", int'(level),    1);
        chk("empty_push_valid", int'(rd_valid), 1);
        chk("empty_push_data",  int'(rd_data),  8'h3C);
        step();
        rd_ready = 1'b0;
        chk("empty_push_popped", int'(level), 0);

        // Mid-operation asynchronous reset with wrapped pointers.
        for (int i = 0; i < 5; i++) push_byte(8'h50 + 8'(i));
        chk("pre_reset_level", int'(level), 5);
        #1 reset = 1'b0;
        #1;
        chk("async_rst_level", int'(level),    0);
        chk("async_rst_empty", int'(empty),    1);
        chk("async_rst_valid", int'(rd_valid), 0);
        step();
        reset = 1'b1;
        step();

        // Mixed traffic checked by the per-cycle compare.
        for (int i = 0; i < 400; i++) begin
            rdy         = 1'($urandom_range(0, 1));
            din         = 8'($urandom_range(0, 255));
            rd_ready    = ($urandom_range(0, 3) == 0);
            clr_overrun = ($urandom_range(0, 15) == 0);
            step();
        end
        rdy = 1'b0; rd_ready = 1'b0; clr_overrun = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
